// File: rtl/control_pkg.sv
// Shared control-path types and interrupt constants.
// Used by interrupt_controller and Schematic_Control.
package control_pkg;

  localparam int NUM_IRQ = 8;
  localparam logic [15:0] VEC_BASE = 16'h0100;
  localparam logic [15:0] VEC_STRIDE = 16'h0010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } ctrlState_t;

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder, lowest set index wins.
// Purely combinational.
module irq_priority_enc #(
  parameter int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx = '0;
    // Scan downward so the lowest index is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latched, masked, fixed-priority interrupt controller.
// Hands one interrupt at a time to the control FSM.
module interrupt_controller #(
  parameter int NUM_IRQ = control_pkg::NUM_IRQ,
  parameter logic [15:0] VEC_BASE = control_pkg::VEC_BASE,
  parameter logic [15:0] VEC_STRIDE = control_pkg::VEC_STRIDE
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic [NUM_IRQ-1:0] HardwareInterrupt,
  input  logic               EnableWrite,
  input  logic [NUM_IRQ-1:0] EnableData,
  input  logic               IrqAck,
  input  logic               IrqRet,
  output logic               InterruptIn,
  output logic [15:0]        Vector,
  output logic [NUM_IRQ-1:0] Flipped,
  output logic               InService
);

  import control_pkg::*;

  localparam int IdW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  ctrlState_t state;
  ctrlState_t stateNext;

  logic [NUM_IRQ-1:0] hwPrev;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] pendNext;
  logic [NUM_IRQ-1:0] armed;

  logic [IdW-1:0] id;
  logic [IdW-1:0] idNext;
  logic [IdW-1:0] winIdx;
  logic           winValid;
  logic [15:0]    winIdx16;
  logic [15:0]    winVec;

  logic               intNext;
  logic               svcNext;
  logic [15:0]        vecNext;
  logic [NUM_IRQ-1:0] flipNext;

  assign rise = HardwareInterrupt & ~hwPrev;
  assign armed = pending & enable;

  always_comb begin
    clr = '0;
    if (state == REQ && IrqAck) clr[id] = 1'b1;
  end

  // A fresh edge beats the acknowledge clear on the same line.
  assign pendNext = (pending & ~clr) | rise;

  irq_priority_enc #(
    .N(NUM_IRQ)
  ) u_enc (
    .req  (armed),
    .valid(winValid),
    .idx  (winIdx)
  );

  assign winIdx16 = 16'(winIdx);
  assign winVec = VEC_BASE + winIdx16 * VEC_STRIDE;

  always_comb begin
    stateNext = state;
    idNext = id;
    intNext = InterruptIn;
    svcNext = InService;
    vecNext = Vector;
    flipNext = Flipped;
    unique case (state)
      IDLE: begin
        if (winValid) begin
          stateNext = REQ;
          idNext = winIdx;
          intNext = 1'b1;
          svcNext = 1'b0;
          vecNext = winVec;
          flipNext = '0;
          flipNext[winIdx] = 1'b1;
        end
      end
      REQ: begin
        if (IrqAck) begin
          stateNext = SERVICE;
          intNext = 1'b0;
          svcNext = 1'b1;
        end
      end
      SERVICE: begin
        if (IrqRet) begin
          stateNext = IDLE;
          svcNext = 1'b0;
          vecNext = '0;
          flipNext = '0;
        end
      end
      default: begin
        stateNext = IDLE;
        intNext = 1'b0;
        svcNext = 1'b0;
        vecNext = '0;
        flipNext = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      id <= '0;
      hwPrev <= '0;
      pending <= '0;
      enable <= '0;
    end else begin
      state <= stateNext;
      id <= idNext;
      hwPrev <= HardwareInterrupt;
      pending <= pendNext;
      if (EnableWrite) enable <= EnableData;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      InterruptIn <= 1'b0;
      InService <= 1'b0;
      Vector <= '0;
      Flipped <= '0;
    end else begin
      InterruptIn <= intNext;
      InService <= svcNext;
      Vector <= vecNext;
      Flipped <= flipNext;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller.
// Inputs change and outputs are sampled on the falling edge.
module tb_interrupt_controller;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic [7:0] HardwareInterrupt = '0;
  logic       EnableWrite = 1'b0;
  logic [7:0] EnableData = '0;
  logic       IrqAck = 1'b0;
  logic       IrqRet = 1'b0;
  logic       InterruptIn;
  logic [15:0] Vector;
  logic [7:0] Flipped;
  logic       InService;

  int checks = 0;
  int errors = 0;

  interrupt_controller dut (
    .CLK              (CLK),
    .RSTn             (RSTn),
    .HardwareInterrupt(HardwareInterrupt),
    .EnableWrite      (EnableWrite),
    .EnableData       (EnableData),
    .IrqAck           (IrqAck),
    .IrqRet           (IrqRet),
    .InterruptIn      (InterruptIn),
    .Vector           (Vector),
    .Flipped          (Flipped),
    .InService        (InService)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic expOut(input string name, input logic ei,
                        input logic es, input logic [15:0] ev,
                        input logic [7:0] ef);
    checks++;
    if (InterruptIn !== ei || InService !== es ||
        Vector !== ev || Flipped !== ef) begin
      errors++;
      $display("FAIL %s: got int=%b svc=%b vec=%h flip=%b want int=%b svc=%b vec=%h flip=%b",
               name, InterruptIn, InService, Vector, Flipped, ei, es, ev, ef);
    end
  endtask

  task automatic setEnable(input logic [7:0] m);
    EnableWrite = 1'b1;
    EnableData = m;
    cyc();
    EnableWrite = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] lines);
    HardwareInterrupt = lines;
    cyc();
    HardwareInterrupt = '0;
  endtask

  task automatic ack();
    IrqAck = 1'b1;
    cyc();
    IrqAck = 1'b0;
  endtask

  task automatic ret();
    IrqRet = 1'b1;
    cyc();
    IrqRet = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    expOut("reset_hold", 1'b0, 1'b0, 16'h0000, 8'h00);
    RSTn = 1'b1;
    cyc();
    expOut("reset_idle", 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic test_single();
    setEnable(8'hFF);
    pulse(8'h08);
    expOut("single_k", 1'b0, 1'b0, 16'h0000, 8'h00);
    cyc();
    expOut("single_req", 1'b1, 1'b0, 16'h0130, 8'h08);
    ret();
    expOut("single_ret_in_req", 1'b1, 1'b0, 16'h0130, 8'h08);
    ack();
    expOut("single_ack", 1'b0, 1'b1, 16'h0130, 8'h08);
    ack();
    expOut("single_ack_in_svc", 1'b0, 1'b1, 16'h0130, 8'h08);
    ret();
    expOut("single_ret", 1'b0, 1'b0, 16'h0000, 8'h00);
    cyc();
    expOut("single_quiet", 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic test_priority();
    pulse(8'h24);
    cyc();
    expOut("prio_first", 1'b1, 1'b0, 16'h0120, 8'h04);
    ack();
    ret();
    expOut("prio_idle", 1'b0, 1'b0, 16'h0000, 8'h00);
    cyc();
    expOut("prio_second", 1'b1, 1'b0, 16'h0150, 8'h20);
    ack();
    ret();
    cyc();
    expOut("prio_drained", 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic test_mask();
    setEnable(8'h00);
    pulse(8'h02);
    cyc();
    cyc();
    expOut("mask_blocked", 1'b0, 1'b0, 16'h0000, 8'h00);
    setEnable(8'h02);
    expOut("mask_write_edge", 1'b0, 1'b0, 16'h0000, 8'h00);
    cyc();
    expOut("mask_released", 1'b1, 1'b0, 16'h0110, 8'h02);
    setEnable(8'h00);
    expOut("mask_no_withdraw", 1'b1, 1'b0, 16'h0110, 8'h02);
    ack();
    ret();
    setEnable(8'hFF);
  endtask

  task automatic test_no_nesting();
    pulse(8'h10);
    cyc();
    expOut("nest_req4", 1'b1, 1'b0, 16'h0140, 8'h10);
    ack();
    pulse(8'h01);
    cyc();
    cyc();
    expOut("nest_blocked", 1'b0, 1'b1, 16'h0140, 8'h10);
    ret();
    expOut("nest_idle", 1'b0, 1'b0, 16'h0000, 8'h00);
    cyc();
    expOut("nest_req0", 1'b1, 1'b0, 16'h0100, 8'h01);
    ack();
    ret();
  endtask

  task automatic test_ack_rerise();
    pulse(8'h08);
    cyc();
    expOut("rerise_req", 1'b1, 1'b0, 16'h0130, 8'h08);
    HardwareInterrupt = 8'h08;
    IrqAck = 1'b1;
    cyc();
    HardwareInterrupt = '0;
    IrqAck = 1'b0;
    expOut("rerise_svc", 1'b0, 1'b1, 16'h0130, 8'h08);
    ret();
    expOut("rerise_idle", 1'b0, 1'b0, 16'h0000, 8'h00);
    cyc();
    expOut("rerise_again", 1'b1, 1'b0, 16'h0130, 8'h08);
    ack();
    ret();
  endtask

  task automatic test_reset_midreq();
    pulse(8'h40);
    cyc();
    expOut("rst_req6", 1'b1, 1'b0, 16'h0160, 8'h40);
    #2 RSTn = 1'b0;
    #1;
    expOut("rst_async", 1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge CLK);
    RSTn = 1'b1;
    setEnable(8'hFF);
    cyc();
    expOut("rst_pending_gone", 1'b0, 1'b0, 16'h0000, 8'h00);
    IrqAck = 1'b1;
    IrqRet = 1'b1;
    cyc();
    IrqAck = 1'b0;
    IrqRet = 1'b0;
    cyc();
    expOut("spurious_idle", 1'b0, 1'b0, 16'h0000, 8'h00);
    pulse(8'h80);
    cyc();
    expOut("post_rst_req7", 1'b1, 1'b0, 16'h0170, 8'h80);
  endtask

  initial begin
    fork
      begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_no_nesting();
    test_ack_rerise();
    test_reset_midreq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
